// File: rtl/mm_sequencer.sv
// mm_sequencer
// Control FSM for a tiled matrix multiplication. It fetches a packed
// dimension word, validates it, and then issues a sequence of load,
// compute and store operation codes to the address controller. Each C
// block is processed as n/8 chunks of one LDA followed by eight LDB, then
// one MAC and one STC. Every operation is followed by a single idle-code
// GAP cycle, so consecutive identical codes are always visible as a
// change on inst.
//
// Optional feature: define MM_SEQ_TIMEOUT_EN to enable a watchdog. The
// watchdog moves the FSM to ERR if an operation waits TIMEOUT_CYCLES
// cycles without its completion pulse. When the macro is not defined,
// the build has no watchdog logic and waits are unbounded.

module mm_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dim_rdata,
    input  logic        mem_ack,
    input  logic        mac_done,
    input  logic        mm_complete,
    output logic [2:0]  inst,
    output logic        inst_valid,
    output logic        dim_we,
    output logic [31:0] dim_word,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIM,
        S_CHK,
        S_LDA,
        S_LDB,
        S_MAC,
        S_STC,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] INST_DIM  = 3'd0;
    localparam logic [2:0] INST_LDA  = 3'd1;
    localparam logic [2:0] INST_LDB  = 3'd2;
    localparam logic [2:0] INST_STC  = 3'd3;
    localparam logic [2:0] INST_MAC  = 3'd4;
    localparam logic [2:0] INST_NONE = 3'd6;

    // Number of B loads that follow each A chunk load.
    localparam logic [3:0] B_PER_CHUNK = 4'd8;

    // The watchdog compares against TIMEOUT_CYCLES-1, so zero is meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mm_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    // State and bookkeeping registers.
    state_t      r_state;
    state_t      r_gap_next;
    logic        r_first;
    logic [31:0] r_dim_word;
    logic [20:0] r_blk_cnt;
    logic [7:0]  r_chunks_per_blk;
    logic [7:0]  r_chunk_cnt;
    logic [3:0]  r_b_cnt;

    // Combinational decode.
    state_t      w_next_state;
    state_t      w_gap_dest;
    logic [10:0] w_m;
    logic [10:0] w_n;
    logic [9:0]  w_o;
    logic        w_dim_bad;
    logic        w_is_op;
    logic        w_ack;
    logic        w_last_b;
    logic        w_last_chunk;
    logic        w_last_blk;
    logic        w_mmc_err;
    logic        w_timeout;

    // Dimension fields come from the latched word, not the live memory bus.
    assign w_m = r_dim_word[10:0];
    assign w_n = r_dim_word[21:11];
    assign w_o = r_dim_word[31:22];

    // Zero dimensions, or n or o not a multiple of 8, cannot be tiled.
    assign w_dim_bad = (w_m == 11'd0) || (w_n == 11'd0) || (w_o == 10'd0)
                    || (w_n[2:0] != 3'd0) || (w_o[2:0] != 3'd0);

    assign w_is_op = (r_state inside {S_DIM, S_LDA, S_LDB, S_MAC, S_STC});

    // Only the completion pulse that the current op waits for counts.
    // A stray pulse of the other kind, or any pulse outside an op, is dropped.
    assign w_ack = (r_state == S_MAC) ? mac_done : (w_is_op && mem_ack);

    assign w_last_b     = (r_b_cnt == 4'd1);
    assign w_last_chunk = (r_chunk_cnt == 8'd1);
    assign w_last_blk   = (r_blk_cnt == 21'd1);

    // The address controller may report completion only after the final
    // store has been acknowledged. The final STC and the GAP that leads to
    // DONE are exempt. IDLE, DONE and ERR ignore the flag.
    assign w_mmc_err = mm_complete && (
                           (r_state inside {S_DIM, S_CHK, S_LDA, S_LDB, S_MAC})
                        || ((r_state == S_STC) && !w_last_blk)
                        || ((r_state == S_GAP) && (r_gap_next != S_DONE)));

`ifdef MM_SEQ_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait_cnt;

    // Count the cycles spent in the current op; any state change restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_is_op) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // The last permitted wait cycle has passed without the expected pulse.
    assign w_timeout = w_is_op && !w_ack && (r_wait_cnt == WAIT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic. GAP always jumps to the destination chosen on the ack edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first. Otherwise a
        // path that skips the assignment would infer a latch.
        w_next_state = r_state;
        w_gap_dest   = r_gap_next;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_DIM;
            end
            S_DIM: begin
                if (w_ack) begin
                    w_next_state = S_GAP;
                    w_gap_dest   = S_CHK;
                end
            end
            S_CHK: begin
                w_next_state = w_dim_bad ? S_ERR : S_LDA;
            end
            S_LDA: begin
                if (w_ack) begin
                    w_next_state = S_GAP;
                    w_gap_dest   = S_LDB;
                end
            end
            S_LDB: begin
                if (w_ack) begin
                    w_next_state = S_GAP;
                    if (!w_last_b)         w_gap_dest = S_LDB;
                    else if (w_last_chunk) w_gap_dest = S_MAC;
                    else                   w_gap_dest = S_LDA;
                end
            end
            S_MAC: begin
                if (w_ack) begin
                    w_next_state = S_GAP;
                    w_gap_dest   = S_STC;
                end
            end
            S_STC: begin
                if (w_ack) begin
                    w_next_state = S_GAP;
                    w_gap_dest   = w_last_blk ? S_DONE : S_LDA;
                end
            end
            S_GAP: begin
                w_next_state = r_gap_next;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                if (start) w_next_state = S_DIM;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_mmc_err || w_timeout) w_next_state = S_ERR;
    end

    // State register. r_first marks the first cycle after any state change.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gap_next <= S_IDLE;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_gap_next <= w_gap_dest;
            r_first    <= (w_next_state != r_state);
        end
    end

    // Capture the dimension word on the edge that carries the DIM load ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dim_word <= '0;
        end else if ((r_state == S_DIM) && w_ack) begin
            r_dim_word <= dim_rdata;
        end
    end

    // Loop counters: loaded in CHK, stepped on LDB and STC acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_cnt        <= '0;
            r_chunks_per_blk <= '0;
            r_chunk_cnt      <= '0;
            r_b_cnt          <= '0;
        end else if ((r_state == S_CHK) && !w_dim_bad) begin
            r_blk_cnt        <= {10'd0, w_m} * {14'd0, w_o[9:3]};
            r_chunks_per_blk <= w_n[10:3];
            r_chunk_cnt      <= w_n[10:3];
            r_b_cnt          <= B_PER_CHUNK;
        end else if (w_ack && (r_state == S_LDB)) begin
            if (w_last_b) begin
                r_b_cnt <= B_PER_CHUNK;
                if (!w_last_chunk) r_chunk_cnt <= r_chunk_cnt - 8'd1;
            end else begin
                r_b_cnt <= r_b_cnt - 4'd1;
            end
        end else if (w_ack && (r_state == S_STC)) begin
            r_blk_cnt   <= r_blk_cnt - 21'd1;
            r_chunk_cnt <= r_chunks_per_blk;
            r_b_cnt     <= B_PER_CHUNK;
        end
    end

    // Operation code. It is held for the whole wait and is idle everywhere else.
    always_comb begin
        inst = INST_NONE;
        unique case (r_state)
            S_DIM:   inst = INST_DIM;
            S_LDA:   inst = INST_LDA;
            S_LDB:   inst = INST_LDB;
            S_MAC:   inst = INST_MAC;
            S_STC:   inst = INST_STC;
            default: inst = INST_NONE;
        endcase
    end

    assign inst_valid = w_is_op && r_first;
    assign dim_we     = (r_state == S_CHK);
    assign dim_word   = r_dim_word;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer
// Self-checking bench for mm_sequencer. A memory/MAC responder answers each
// issued operation after a programmable delay. The expected opcode stream
// for a job is generated from the dimension rules by a small model, and
// hand-computed issue counts in a vector table cross-check that model.
// Outputs are sampled on the falling edge, and inputs change there too.
// If MM_SEQ_TIMEOUT_EN is defined, the same macro selects the watchdog
// expectations.

module tb_mm_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dim_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mac_done = 1'b0;
    logic        mm_complete = 1'b0;
    logic [2:0]  inst;
    logic        inst_valid;
    logic        dim_we;
    logic [31:0] dim_word;
    logic        busy;
    logic        done;
    logic        error;

    mm_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dim_rdata   (dim_rdata),
        .mem_ack     (mem_ack),
        .mac_done    (mac_done),
        .mm_complete (mm_complete),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .dim_we      (dim_we),
        .dim_word    (dim_word),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Per-job observation state.
    int issues[$];
    int exp_q[$];
    int n_dimwe;
    int n_done;
    int proto_bad;
    int prev_inst = 6;
    int mac_issued;

    // Responder configuration and pending-ack state.
    int ack_cnt = 0;
    bit ack_is_mac = 1'b0;
    int max_delay = 1;
    bit spurious = 1'b0;
    bit withhold_lda = 1'b0;

    typedef struct {
        int m;
        int n;
        int o;
        bit exp_err;
        int exp_issues;
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pack(input int m, input int n, input int o);
        logic [31:0] w;
        w = {o[9:0], n[10:0], m[10:0]};
        return w;
    endfunction

    // Expected opcode stream from the tiling rules.
    task automatic build_expected(input int m, input int n, input int o);
        bit ok;
        ok = (m != 0) && (n != 0) && (o != 0) && (n % 8 == 0) && (o % 8 == 0);
        exp_q.delete();
        exp_q.push_back(0);
        if (ok) begin
            for (int b = 0; b < m * (o / 8); b++) begin
                for (int c = 0; c < n / 8; c++) begin
                    exp_q.push_back(1);
                    for (int k = 0; k < 8; k++) exp_q.push_back(2);
                end
                exp_q.push_back(4);
                exp_q.push_back(3);
            end
        end
    endtask

    // One clock cycle: observe outputs on the falling edge, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        start    = 1'b0;
        mem_ack  = 1'b0;
        mac_done = 1'b0;
        if (inst_valid) begin
            issues.push_back(int'(inst));
            if (inst == 3'd4) mac_issued++;
            if (inst == 3'd6 || prev_inst != 6 || !busy) proto_bad++;
        end else if (inst != 3'd6 && int'(inst) != prev_inst) begin
            proto_bad++;
        end
        if (dim_we) n_dimwe++;
        if (done) n_done++;
        prev_inst = int'(inst);
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                if (ack_is_mac) mac_done = 1'b1;
                else            mem_ack  = 1'b1;
            end
        end
        if (inst_valid && !(withhold_lda && inst == 3'd1)) begin
            ack_cnt    = (max_delay > 1) ? int'($urandom_range(max_delay, 1)) : 1;
            ack_is_mac = (inst == 3'd4);
        end
        if (spurious && busy && !error) begin
            if (inst == 3'd2 && $urandom_range(1, 0) == 1) mac_done = 1'b1;
            if (inst == 3'd4 && !mac_done && $urandom_range(1, 0) == 1) mem_ack = 1'b1;
            if ($urandom_range(3, 0) == 0) start = 1'b1;
        end
    endtask

    task automatic begin_job(input logic [31:0] dim, input int max_d, input bit spur);
        issues.delete();
        n_dimwe      = 0;
        n_done       = 0;
        proto_bad    = 0;
        mac_issued   = 0;
        ack_cnt      = 0;
        max_delay    = max_d;
        spurious     = spur;
        withhold_lda = 1'b0;
        dim_rdata    = dim;
        step();
        start = 1'b1;
    endtask

    task automatic finish_job(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (done || error) begin
                timed_out = 1'b0;
                break;
            end
        end
        step();
    endtask

    task automatic run_job(input logic [31:0] dim, input int max_d, input bit spur, output bit timed_out);
        begin_job(dim, max_d, spur);
        finish_job(timed_out);
    endtask

    task automatic check_job(input string tag, input int m, input int n, input int o, input bit timed_out);
        bit ok;
        int mism;
        int lim;
        ok = (m != 0) && (n != 0) && (o != 0) && (n % 8 == 0) && (o % 8 == 0);
        build_expected(m, n, o);
        mism = 0;
        lim = (issues.size() < exp_q.size()) ? issues.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (issues[i] != exp_q[i]) mism++;
        check($sformatf("%s/ended", tag), timed_out, 0);
        check($sformatf("%s/issue_count", tag), issues.size(), exp_q.size());
        check($sformatf("%s/issue_order", tag), mism, 0);
        check($sformatf("%s/dim_we_pulses", tag), n_dimwe, 1);
        check($sformatf("%s/done_pulses", tag), n_done, ok ? 1 : 0);
        check($sformatf("%s/error", tag), error, ok ? 0 : 1);
        check($sformatf("%s/busy", tag), busy, ok ? 0 : 1);
        check($sformatf("%s/dim_word", tag), dim_word, pack(m, n, o));
        check($sformatf("%s/protocol", tag), proto_bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s/inst", tag), inst, 6);
        check($sformatf("%s/inst_valid", tag), inst_valid, 0);
        check($sformatf("%s/dim_we", tag), dim_we, 0);
        check($sformatf("%s/dim_word", tag), dim_word, 0);
        check($sformatf("%s/busy", tag), busy, 0);
        check($sformatf("%s/done", tag), done, 0);
        check($sformatf("%s/error", tag), error, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t        vecs[12];
        bit          to;
        bit          found;
        int          rm, rn, ro, rd;
        int          waited;

        vecs[0]  = '{8, 8, 8, 1'b0, 89};
        vecs[1]  = '{1, 8, 8, 1'b0, 12};
        vecs[2]  = '{2, 16, 8, 1'b0, 41};
        vecs[3]  = '{1, 8, 16, 1'b0, 23};
        vecs[4]  = '{3, 24, 24, 1'b0, 262};
        vecs[5]  = '{1, 2040, 8, 1'b0, 2298};
        vecs[6]  = '{1, 8, 1016, 1'b0, 1398};
        vecs[7]  = '{8, 12, 8, 1'b1, 1};
        vecs[8]  = '{0, 8, 8, 1'b1, 1};
        vecs[9]  = '{4, 0, 8, 1'b1, 1};
        vecs[10] = '{4, 8, 0, 1'b1, 1};
        vecs[11] = '{2047, 2047, 1020, 1'b1, 1};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // The first start after reset is taken on the next edge.
        begin_job(pack(1, 8, 8), 1, 1'b0);
        step();
        check("first_start/inst_valid", inst_valid, 1);
        check("first_start/inst", inst, 0);
        finish_job(to);
        check_job("first_start", 1, 8, 8, to);

        // Vector table: hand-computed issue counts and error outcomes.
        for (int v = 0; v < 12; v++) begin
            run_job(pack(vecs[v].m, vecs[v].n, vecs[v].o), 1, 1'b0, to);
            check($sformatf("vec%0d/hand_issue_count", v), issues.size(), vecs[v].exp_issues);
            check($sformatf("vec%0d/hand_error", v), error, vecs[v].exp_err);
            check_job($sformatf("vec%0d", v), vecs[v].m, vecs[v].n, vecs[v].o, to);
        end

        // Random jobs with variable ack latency, stray pulses and ignored starts.
        for (int j = 0; j < 12; j++) begin
            rm = $urandom_range(3, 1);
            rn = 8 * $urandom_range(3, 1);
            ro = 8 * $urandom_range(2, 1);
            case ($urandom_range(5, 0))
                0:       rn = rn + $urandom_range(7, 1);
                1:       rm = 0;
                2:       ro = ro + $urandom_range(7, 1);
                default: ;
            endcase
            rd = $urandom_range(3, 1);
            run_job(pack(rm, rn, ro), rd, 1'b1, to);
            check_job($sformatf("rand%0d", j), rm, rn, ro, to);
        end

        // mm_complete raised during the third block's LDB.
        begin_job(pack(8, 8, 8), 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (inst_valid && inst == 3'd2 && mac_issued == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("mmc/reached_block3_ldb", found, 1);
        mm_complete = 1'b1;
        step();
        check("mmc/error", error, 1);
        check("mmc/inst", inst, 6);
        check("mmc/busy", busy, 1);
        mm_complete = 1'b0;
        repeat (5) step();
        check("mmc/error_sticky", error, 1);
        check("mmc/inst_idle", inst, 6);
        run_job(pack(8, 8, 8), 1, 1'b0, to);
        check_job("after_err", 8, 8, 8, to);

        // Asynchronous reset during the MAC of block 2.
        begin_job(pack(8, 8, 8), 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (inst_valid && inst == 3'd4 && mac_issued == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst/reached_mac2", found, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ack_cnt = 0;
        step();
        reset_n = 1'b1;
        run_job(pack(8, 8, 8), 1, 1'b0, to);
        check_job("after_midrst", 8, 8, 8, to);

        // mem_ack withheld for the first LDA.
        begin_job(pack(8, 8, 8), 1, 1'b0);
        withhold_lda = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (inst_valid && inst == 3'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("stall/reached_lda", found, 1);
`ifdef MM_SEQ_TIMEOUT_EN
        waited = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            waited = i;
            if (error) break;
        end
        check("stall/timeout_cycles", waited, 255);
        check("stall/error", error, 1);
`else
        waited = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (inst == 3'd1 && busy && !error) waited++;
        end
        check("stall/cycles_in_lda", waited, 300);
        check("stall/inst", inst, 1);
        check("stall/inst_valid", inst_valid, 0);
        check("stall/error", error, 0);
`endif
        reset_n = 1'b0;
        withhold_lda = 1'b0;
        ack_cnt = 0;
        step();
        reset_n = 1'b1;
        run_job(pack(2, 8, 8), 2, 1'b1, to);
        check_job("after_stall", 2, 8, 8, to);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_sequencer.md
MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles spent waiting on mem_ack or mac_done before a watchdog error (used only with MM_SEQ_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin one matrix multiplication; sampled only in IDLE.
REQ-005 dim_rdata  input  32  packed dimension word from data memory: [10:0]=m, [21:11]=n, [31:22]=o.
REQ-006 mem_ack  input  1  one-cycle completion pulse for an issued load/store (inst 0,1,2,3).
REQ-007 mac_done  input  1  one-cycle completion pulse for an issued compute (inst 4).
REQ-008 mm_complete  input  1  completion flag from the address controller.
REQ-009 inst  output  3  operation code to the address controller.
REQ-010 inst_valid  output  1  high exactly in the issue cycle of each operation.
REQ-011 dim_we  output  1  one-cycle write strobe for dim_word.
REQ-012 dim_word  output  32  registered copy of dim_rdata.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 error  output  1  sticky error flag, cleared only by reset or next accepted start.

Function
REQ-016 States SHALL be IDLE, DIM, CHK, LDA, LDB, MAC, STC, GAP, DONE, ERR.
REQ-017 Each op state SHALL drive inst for the whole wait, inst_valid only in its first cycle; idle code 3'd6 in all other states.
REQ-018 Every op state SHALL be followed by exactly one GAP cycle (inst=6) so that consecutive identical codes produce a value change.
REQ-019 IDLE->DIM on start; DIM issues inst=0, waits mem_ack, latches dim_rdata into dim_word on the ack edge.
REQ-020 CHK SHALL pulse dim_we for one cycle and go to ERR if m, n or o is zero, or n[2:0]!=0, or o[2:0]!=0; else to LDA.
REQ-021 C block count SHALL be computed as m*(o/8) in a 21-bit register; A chunk count n/8; B loads per chunk 8.
REQ-022 Per C block: for each of n/8 chunks issue one LDA (inst=1) then eight LDB (inst=2), each waiting mem_ack; then MAC (inst=4) waits mac_done; then STC (inst=3) waits mem_ack.
REQ-023 After STC, decrement block counter; nonzero -> LDA with chunk/B counters reloaded, zero -> DONE.
REQ-024 DONE SHALL pulse done one cycle then return to IDLE.
REQ-025 mm_complete high in any state before the final STC ack SHALL go to ERR.
REQ-026 mem_ack or mac_done arriving in a state not waiting for it SHALL be ignored.
REQ-027 ERR SHALL hold error=1, busy=1, inst=6 until start, which clears error and goes to DIM.
REQ-028 start while busy (outside ERR) SHALL be ignored.

Reset
REQ-029 reset_n low SHALL force IDLE immediately, including mid-operation: inst=6, inst_valid=0, dim_we=0, dim_word=0, busy=0, done=0, error=0, all counters 0.
REQ-030 First start after reset_n deasserts SHALL be accepted on the next rising edge.

Configuration
REQ-031 Macro MM_SEQ_TIMEOUT_EN defined: an 8-bit+ wait counter resets at each issue; reaching TIMEOUT_CYCLES without the expected ack -> ERR.
REQ-032 MM_SEQ_TIMEOUT_EN undefined: no watchdog logic; waits are unbounded.

Verification
REQ-033 m=8,n=8,o=8, ack 1 cycle after each issue -> sequence 0,1,2x8,4,3 repeated 8 blocks, each op followed by inst=6, done pulse, error=0.
REQ-034 dim_rdata with n=12 -> dim_we pulse, ERR, error=1, no inst 1..4 issued.
REQ-035 mm_complete forced high during third block's LDB -> ERR within one cycle.
REQ-036 reset_n low during MAC of block 2 -> all outputs at reset values same cycle; new start gives full clean run.
REQ-037 With MM_SEQ_TIMEOUT_EN, mem_ack withheld in LDA -> error after 255 cycles; without macro, FSM stays in LDA indefinitely.
REQ-038 Spurious mac_done during LDB and start pulses while busy -> sequence unchanged.
